// File: rtl/cbus_clint_splitter.sv
// CBus splitter between the arbiter and RAM: CLINT-window accesses are served locally
// (msip/mtimecmp/mtime, trint/swint); all others pass through. Optional macro: CLINT_MTIME_WR_EN.
module cbus_clint_splitter #(
    parameter logic [63:0] CLINT_BASE = 64'h0000_0000_0200_0000,
    parameter int unsigned MTIME_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    // request from arbiter
    input  logic        ireq_valid,
    input  logic        ireq_is_write,
    input  logic [2:0]  ireq_size,
    input  logic [63:0] ireq_addr,
    input  logic [7:0]  ireq_strobe,
    input  logic [63:0] ireq_data,
    input  logic [7:0]  ireq_len,
    input  logic [1:0]  ireq_burst,
    // response to arbiter
    output logic        iresp_ready,
    output logic        iresp_last,
    output logic [63:0] iresp_data,
    // request to RAM
    output logic        oreq_valid,
    output logic        oreq_is_write,
    output logic [2:0]  oreq_size,
    output logic [63:0] oreq_addr,
    output logic [7:0]  oreq_strobe,
    output logic [63:0] oreq_data,
    output logic [7:0]  oreq_len,
    output logic [1:0]  oreq_burst,
    // response from RAM
    input  logic        oresp_ready,
    input  logic        oresp_last,
    input  logic [63:0] oresp_data,
    // interrupts to core
    output logic        trint,
    output logic        swint
);

    localparam int unsigned PRE_W = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MTIME_DIV - 1);

    localparam logic [12:0] OFF_MSIP     = 13'h0000;
    localparam logic [12:0] OFF_MTIMECMP = 13'h0800;
    localparam logic [12:0] OFF_MTIME    = 13'h17FF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_LOCAL
    } state_t;

    state_t             state_q, state_d;
    logic [12:0]        off_q, off_d;
    logic               wr_q, wr_d;
    logic [7:0]         strb_q, strb_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         beat_q, beat_d;

    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        mtimecmp_q, mtimecmp_d;
    logic               msip_q, msip_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               trint_q, trint_d;
    logic               swint_q, swint_d;

    logic [63:0]        win_off;
    logic               hit;
    logic               first_beat;
    logic               local_wr;
    logic               tick;
    logic [63:0]        rdata;

    // Unsigned subtraction wraps addresses below the base to large values, so one compare decodes the window.
    assign win_off = ireq_addr - CLINT_BASE;
    assign hit     = (win_off < 64'h1_0000);

    assign first_beat = (state_q == ST_LOCAL) && (beat_q == 8'd0);
    assign local_wr   = first_beat && wr_q;

    // Bus routing and FSM next state
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        wr_d    = wr_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        len_d   = len_q;
        beat_d  = beat_q;

        oreq_valid    = 1'b0;
        oreq_is_write = ireq_is_write;
        oreq_size     = ireq_size;
        oreq_addr     = ireq_addr;
        oreq_strobe   = ireq_strobe;
        oreq_data     = ireq_data;
        oreq_len      = ireq_len;
        oreq_burst    = ireq_burst;
        iresp_ready   = 1'b0;
        iresp_last    = 1'b0;
        iresp_data    = '0;

        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    if (ireq_valid) begin
                        state_d = ST_LOCAL;
                        off_d   = ireq_addr[15:3];
                        wr_d    = ireq_is_write;
                        strb_d  = ireq_strobe;
                        wdata_d = ireq_data;
                        len_d   = ireq_len;
                        beat_d  = '0;
                    end
                end else begin
                    oreq_valid  = ireq_valid;
                    iresp_ready = oresp_ready;
                    iresp_last  = oresp_last;
                    iresp_data  = oresp_data;
                    // A RAM that completes in the request cycle leaves the FSM in IDLE.
                    if (ireq_valid && !(oresp_ready && oresp_last)) begin
                        state_d = ST_FWD;
                    end
                end
            end
            ST_FWD: begin
                oreq_valid  = ireq_valid;
                iresp_ready = oresp_ready;
                iresp_last  = oresp_last;
                iresp_data  = oresp_data;
                if (oresp_ready && oresp_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCAL: begin
                iresp_ready = 1'b1;
                iresp_last  = (beat_q == len_q);
                iresp_data  = first_beat ? rdata : '0;
                beat_d      = beat_q + 8'd1;
                if (beat_q == len_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reset) begin
            oreq_valid  = 1'b0;
            iresp_ready = 1'b0;
            iresp_last  = 1'b0;
            iresp_data  = '0;
        end
    end

    // CLINT register file, timer and interrupt lines
    always_comb begin
        tick       = (pre_q == PRE_LAST);
        pre_d      = tick ? '0 : pre_q + PRE_W'(1);
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;

        case (off_q)
            OFF_MSIP:     rdata = {63'd0, msip_q};
            OFF_MTIMECMP: rdata = mtimecmp_q;
            OFF_MTIME:    rdata = mtime_q;
            default:      rdata = '0;
        endcase

        if (local_wr) begin
            case (off_q)
                OFF_MSIP: begin
                    if (strb_q[0]) begin
                        msip_d = wdata_q[0];
                    end
                end
                OFF_MTIMECMP: begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        if (strb_q[i]) begin
                            mtimecmp_d[8*i +: 8] = wdata_q[8*i +: 8];
                        end
                    end
                end
`ifdef CLINT_MTIME_WR_EN
                // Written bytes override the incremented value; the prescaler keeps running.
                OFF_MTIME: begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        if (strb_q[i]) begin
                            mtime_d[8*i +: 8] = wdata_q[8*i +: 8];
                        end
                    end
                end
`endif
                default: ;
            endcase
        end

        trint_d = (mtime_q >= mtimecmp_q);
        swint_d = msip_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            off_q      <= '0;
            wr_q       <= 1'b0;
            strb_q     <= '0;
            wdata_q    <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            pre_q      <= '0;
            trint_q    <= 1'b0;
            swint_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            wr_q       <= wr_d;
            strb_q     <= strb_d;
            wdata_q    <= wdata_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            pre_q      <= pre_d;
            trint_q    <= trint_d;
            swint_q    <= swint_d;
        end
    end

    assign trint = trint_q;
    assign swint = swint_q;

endmodule

// File: tb/tb_cbus_clint_splitter.sv
// Bench for cbus_clint_splitter: transaction-level CLINT model plus a per-cycle output checker.
module tb_cbus_clint_splitter;

    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

`ifdef CLINT_MTIME_WR_EN
    localparam bit MT_WR = 1'b1;
`else
    localparam bit MT_WR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ireq_valid = 1'b0, ireq_is_write = 1'b0;
    logic [2:0]  ireq_size = '0;
    logic [63:0] ireq_addr = '0, ireq_data = '0;
    logic [7:0]  ireq_strobe = '0, ireq_len = '0;
    logic [1:0]  ireq_burst = '0;
    logic        iresp_ready, iresp_last;
    logic [63:0] iresp_data;
    logic        oreq_valid, oreq_is_write;
    logic [2:0]  oreq_size;
    logic [63:0] oreq_addr, oreq_data;
    logic [7:0]  oreq_strobe, oreq_len;
    logic [1:0]  oreq_burst;
    logic        oresp_ready = 1'b0, oresp_last = 1'b0;
    logic [63:0] oresp_data = '0;
    logic        trint, swint;

    always #5 clk = ~clk;

    cbus_clint_splitter #(.CLINT_BASE(BASE), .MTIME_DIV(1)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_is_write(ireq_is_write), .ireq_size(ireq_size),
        .ireq_addr(ireq_addr), .ireq_strobe(ireq_strobe), .ireq_data(ireq_data),
        .ireq_len(ireq_len), .ireq_burst(ireq_burst),
        .iresp_ready(iresp_ready), .iresp_last(iresp_last), .iresp_data(iresp_data),
        .oreq_valid(oreq_valid), .oreq_is_write(oreq_is_write), .oreq_size(oreq_size),
        .oreq_addr(oreq_addr), .oreq_strobe(oreq_strobe), .oreq_data(oreq_data),
        .oreq_len(oreq_len), .oreq_burst(oreq_burst),
        .oresp_ready(oresp_ready), .oresp_last(oresp_last), .oresp_data(oresp_data),
        .trint(trint), .swint(swint)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (bench runs MTIME_DIV=1: mtime ticks every clock) ----
    logic [63:0] m_mtime = '0, m_cmp = '1;
    logic        m_msip = 1'b0, m_trint = 1'b0, m_swint = 1'b0;
    logic        m_wr = 1'b0;
    logic [63:0] m_wr_addr = '0, m_wr_data = '0;
    logic [7:0]  m_wr_strb = '0;

    function automatic logic [63:0] reg_off(input logic [63:0] a);
        logic [63:0] o;
        o = (a - BASE) & 64'h0000_0000_0000_FFF8;
        return o;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a);
        logic [63:0] o;
        o = reg_off(a);
        if (o == 64'h0)    return {63'd0, m_msip};
        if (o == 64'h4000) return m_cmp;
        if (o == 64'hBFF8) return m_mtime;
        return '0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mtime <= '0;
            m_cmp   <= '1;
            m_msip  <= 1'b0;
            m_trint <= 1'b0;
            m_swint <= 1'b0;
        end else begin
            m_trint <= (m_mtime >= m_cmp);
            m_swint <= m_msip;
            if (m_wr && MT_WR && reg_off(m_wr_addr) == 64'hBFF8)
                m_mtime <= merge(m_mtime + 64'd1, m_wr_data, m_wr_strb);
            else
                m_mtime <= m_mtime + 64'd1;
            if (m_wr && reg_off(m_wr_addr) == 64'h4000)
                m_cmp <= merge(m_cmp, m_wr_data, m_wr_strb);
            if (m_wr && reg_off(m_wr_addr) == 64'h0 && m_wr_strb[0])
                m_msip <= m_wr_data[0];
        end
    end

    // ---------------- per-cycle checker -----------------------------------------------------
    typedef enum logic [1:0] {M_QUIET, M_PASS, M_LOCAL} mode_e;
    mode_e       exp_mode  = M_QUIET;
    logic        exp_first = 1'b0, exp_last = 1'b0;
    logic [63:0] exp_addr  = '0;
    logic        chk_en    = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("trint", 64'(trint), 64'(m_trint));
            chk("swint", 64'(swint), 64'(m_swint));
            case (exp_mode)
                M_QUIET: begin
                    chk("quiet_oreq_valid", 64'(oreq_valid), 64'd0);
                    chk("quiet_iresp_ready", 64'(iresp_ready), 64'd0);
                    chk("quiet_iresp_last", 64'(iresp_last), 64'd0);
                    chk("quiet_iresp_data", iresp_data, 64'd0);
                end
                M_PASS: begin
                    chk("pass_oreq_valid", 64'(oreq_valid), 64'(ireq_valid));
                    chk("pass_oreq_is_write", 64'(oreq_is_write), 64'(ireq_is_write));
                    chk("pass_oreq_size", 64'(oreq_size), 64'(ireq_size));
                    chk("pass_oreq_addr", oreq_addr, ireq_addr);
                    chk("pass_oreq_strobe", 64'(oreq_strobe), 64'(ireq_strobe));
                    chk("pass_oreq_data", oreq_data, ireq_data);
                    chk("pass_oreq_len", 64'(oreq_len), 64'(ireq_len));
                    chk("pass_oreq_burst", 64'(oreq_burst), 64'(ireq_burst));
                    chk("pass_iresp_ready", 64'(iresp_ready), 64'(oresp_ready));
                    chk("pass_iresp_last", 64'(iresp_last), 64'(oresp_last));
                    chk("pass_iresp_data", iresp_data, oresp_data);
                end
                M_LOCAL: begin
                    chk("local_oreq_valid", 64'(oreq_valid), 64'd0);
                    chk("local_iresp_ready", 64'(iresp_ready), 64'd1);
                    chk("local_iresp_last", 64'(iresp_last), 64'(exp_last));
                    chk("local_iresp_data", iresp_data, exp_first ? model_read(exp_addr) : 64'd0);
                end
                default: ;
            endcase
        end
    end

    // ---------------- drivers ---------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic local_access(input logic [63:0] addr, input logic wr, input logic [63:0] wd,
                                input logic [7:0] strb, input logic [7:0] len,
                                output logic [63:0] rd);
        ireq_valid = 1'b1; ireq_is_write = wr; ireq_size = 3'd3; ireq_addr = addr;
        ireq_strobe = strb; ireq_data = wd; ireq_len = len;
        ireq_burst = (len != 8'd0) ? 2'b01 : 2'b00;
        exp_mode = M_QUIET;
        step();
        exp_mode = M_LOCAL; exp_addr = addr; exp_first = 1'b1; exp_last = (len == 8'd0);
        m_wr = wr; m_wr_addr = addr; m_wr_data = wd; m_wr_strb = strb;
        @(negedge clk);
        rd = iresp_data;
        step();
        m_wr = 1'b0; exp_first = 1'b0;
        for (int i = 1; i <= int'(len); i++) begin
            exp_last = (i == int'(len));
            step();
        end
        ireq_valid = 1'b0; ireq_is_write = 1'b0; ireq_addr = '0; ireq_strobe = '0;
        ireq_data = '0; ireq_len = '0; ireq_burst = '0;
        exp_mode = M_QUIET;
    endtask

    // RAM-side burst; optional stall beat during which ireq_addr is moved into the CLINT window.
    task automatic fwd_burst(input logic [63:0] addr, input int nbeats, input int gap_beat,
                             input bit imm, output logic [63:0] last_data, output logic last_flag);
        ireq_valid = 1'b1; ireq_is_write = 1'b0; ireq_size = 3'd3; ireq_addr = addr;
        ireq_strobe = '0; ireq_data = 64'h1234; ireq_len = 8'(nbeats - 1); ireq_burst = 2'b01;
        exp_mode = M_PASS;
        if (!imm) begin
            oresp_ready = 1'b0;
            step();
        end
        for (int b = 0; b < nbeats; b++) begin
            if (b == gap_beat) begin
                oresp_ready = 1'b0; oresp_last = 1'b0; ireq_addr = BASE;
                step();
                ireq_addr = addr;
            end
            oresp_ready = 1'b1; oresp_last = (b == nbeats - 1);
            oresp_data = 64'hA5A5_0000_0000_0000 | 64'(b);
            @(negedge clk);
            last_data = iresp_data;
            last_flag = iresp_last;
            step();
        end
        ireq_valid = 1'b0; ireq_addr = '0; ireq_len = '0; ireq_data = '0; ireq_burst = '0;
        oresp_ready = 1'b0; oresp_last = 1'b0; oresp_data = '0;
        exp_mode = M_QUIET;
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic        lf;
        int          k;

        #2 reset = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // 1: idle after reset; read of mtime lands on the 10th count
        repeat (9) step();
        chk("t1_oreq_valid", 64'(oreq_valid), 64'd0);
        chk("t1_trint", 64'(trint), 64'd0);
        chk("t1_swint", 64'(swint), 64'd0);
        local_access(BASE + 64'hBFF8, 1'b0, '0, '0, 8'd0, rd);
        chk("t1_mtime_read", rd, 64'd10);

        // 2: timer compare
        repeat (8) step();
        local_access(BASE + 64'h4000, 1'b1, 64'd40, 8'hFF, 8'd0, rd);
        k = 0;
        while (trint !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        chk("t2_trint_rise_in_time", 64'(k < 100), 64'd1);
        chk("t2_model_mtime_at_rise", m_mtime, 64'd41);
        local_access(BASE + 64'h4000, 1'b1, '1, 8'hFF, 8'd0, rd);
        chk("t2_trint_lag", 64'(trint), 64'd1);
        step();
        chk("t2_trint_clear", 64'(trint), 64'd0);

        // 3: software interrupt and register map
        local_access(BASE, 1'b1, 64'h1, 8'h01, 8'd0, rd);
        chk("t3_swint_lag", 64'(swint), 64'd0);
        step();
        chk("t3_swint_set", 64'(swint), 64'd1);
        local_access(BASE, 1'b0, '0, '0, 8'd0, rd);
        chk("t3_msip_read", rd, 64'h1);
        local_access(BASE, 1'b1, '1, 8'hFE, 8'd0, rd);
        local_access(BASE, 1'b0, '0, '0, 8'd0, rd);
        chk("t3_msip_unstrobed", rd, 64'h1);
        local_access(BASE + 64'h4004, 1'b0, '0, '0, 8'd2, rd);
        chk("t3_mtimecmp_burst_first", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        local_access(BASE + 64'h0100, 1'b1, '1, 8'hFF, 8'd0, rd);
        local_access(BASE + 64'h0100, 1'b0, '0, '0, 8'd0, rd);
        chk("t3_unmapped_read", rd, 64'd0);
        local_access(BASE + 64'hFFF8, 1'b0, '0, '0, 8'd0, rd);
        chk("t3_window_top", rd, 64'd0);

        // 4: pass-through burst, window edges, same-cycle completion
        fwd_burst(64'h8000_0000, 4, 2, 1'b0, rd, lf);
        chk("t4_last_data", rd, 64'hA5A5_0000_0000_0003);
        chk("t4_last_flag", 64'(lf), 64'd1);
        fwd_burst(BASE - 64'd8, 1, -1, 1'b1, rd, lf);
        chk("t4_below_window", rd, 64'hA5A5_0000_0000_0000);
        fwd_burst(BASE + 64'h1_0000, 1, -1, 1'b0, rd, lf);
        chk("t4_above_window", 64'(lf), 64'd1);
        local_access(BASE, 1'b0, '0, '0, 8'd0, rd);
        chk("t4_local_after_fwd", rd, 64'h1);

        // 5: software write to mtime
        local_access(BASE + 64'hBFF8, 1'b1, 64'h5, 8'hFF, 8'd0, rd);
        local_access(BASE + 64'hBFF8, 1'b0, '0, '0, 8'd0, rd);
`ifdef CLINT_MTIME_WR_EN
        chk("t5_mtime_written", rd, 64'd6);
`else
        chk("t5_mtime_unwritten", 64'(rd > 64'd6), 64'd1);
`endif

        // 6: reset in the middle of a forwarded burst
        ireq_valid = 1'b1; ireq_is_write = 1'b0; ireq_size = 3'd3; ireq_addr = 64'h8000_1000;
        ireq_len = 8'd3; ireq_burst = 2'b01; exp_mode = M_PASS;
        step();
        oresp_ready = 1'b1; oresp_data = 64'hDEAD_BEEF_0000_0001;
        step();
        reset = 1'b1; exp_mode = M_QUIET;
        #1;
        chk("t6_oreq_valid_in_reset", 64'(oreq_valid), 64'd0);
        chk("t6_iresp_ready_in_reset", 64'(iresp_ready), 64'd0);
        chk("t6_iresp_data_in_reset", iresp_data, 64'd0);
        step();
        step();
        reset = 1'b0; ireq_valid = 1'b0; ireq_addr = '0; ireq_len = '0; ireq_burst = '0;
        oresp_ready = 1'b0; oresp_data = '0;
        local_access(BASE + 64'h4000, 1'b0, '0, '0, 8'd0, rd);
        chk("t6_mtimecmp_after_reset", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        local_access(BASE, 1'b0, '0, '0, 8'd0, rd);
        chk("t6_msip_after_reset", rd, 64'd0);
        repeat (2) step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
